// File: rtl/sample_uart_tx.sv
// rtl/sample_uart_tx.sv - FIFO-buffered 16-bit sample serializer onto an 8N1 UART line
// Optional SAMPLE_TX_HEADER_EN prefixes every sample with a 0xA5 sync frame.
module sample_uart_tx #(
  parameter int CLOCK_DIVIDE    = 52,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx,
  output logic        busy,
  output logic        dropped
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int TW    = (CLOCK_DIVIDE > 2) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [TW-1:0]            BIT_LAST   = TW'(CLOCK_DIVIDE - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_LO, PH_HI} phase_t;

`ifdef SAMPLE_TX_HEADER_EN
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam phase_t     FIRST_PHASE = PH_HDR;
`else
  localparam phase_t     FIRST_PHASE = PH_LO;
`endif

  // Sample FIFO
  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       push, pop;

  assign sample_ready = (count < FULL_COUNT);
  assign push         = sample_valid && sample_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sample_valid && !sample_ready) dropped <= 1'b1;
    end
  end

  // Serializer state
  state_t        state, state_nxt;
  phase_t        phase, phase_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt, bit_idx_inc;
  logic [15:0]   hold, hold_nxt;
  logic          tx_nxt, bit_end, fifo_nonempty;
  logic [7:0]    cur_byte;

  assign fifo_nonempty = (count != '0);
  assign bit_end       = (timer == BIT_LAST);
  assign bit_idx_inc   = bit_idx + 3'd1;
  assign busy          = (state != IDLE) || fifo_nonempty;

  always_comb begin
    cur_byte = hold[7:0];
    case (phase)
      PH_LO:   cur_byte = hold[7:0];
      PH_HI:   cur_byte = hold[15:8];
`ifdef SAMPLE_TX_HEADER_EN
      PH_HDR:  cur_byte = SYNC_BYTE;
`endif
      default: cur_byte = hold[7:0];
    endcase
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_idx_nxt = bit_idx;
    hold_nxt    = hold;
    tx_nxt      = tx;
    pop         = 1'b0;
    timer_nxt   = (state == IDLE || bit_end) ? '0 : timer + 1'b1;

    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (fifo_nonempty) begin
          pop       = 1'b1;
          hold_nxt  = mem[rd_ptr];
          phase_nxt = FIRST_PHASE;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = cur_byte[bit_idx_inc];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (phase != PH_HI) begin
            // Next byte of the same sample follows with no idle gap
`ifdef SAMPLE_TX_HEADER_EN
            phase_nxt = (phase == PH_HDR) ? PH_LO : PH_HI;
`else
            phase_nxt = PH_HI;
`endif
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else if (fifo_nonempty) begin
            pop       = 1'b1;
            hold_nxt  = mem[rd_ptr];
            phase_nxt = FIRST_PHASE;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= FIRST_PHASE;
      timer   <= '0;
      bit_idx <= 3'd0;
      hold    <= 16'h0000;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      hold    <= hold_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_sample_uart_tx.sv
// tb/tb_sample_uart_tx.sv - directed self-checking bench for sample_uart_tx
module tb_sample_uart_tx;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        sample_ready, tx, busy, dropped;

  int vectors = 0;
  int miscompares = 0;
  logic exp_bits[$];

  sample_uart_tx #(.CLOCK_DIVIDE(CD), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx(tx), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Expected line bits for one sample, one entry per bit period
  function automatic void add_sample(input logic [15:0] s);
    logic [7:0] b [3];
    int nb;
`ifdef SAMPLE_TX_HEADER_EN
    b[0] = 8'hA5; b[1] = s[7:0]; b[2] = s[15:8]; nb = 3;
`else
    b[0] = s[7:0]; b[1] = s[15:8]; b[2] = 8'h00; nb = 2;
`endif
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(b[i][j]);
      exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_in = 16'h5555;
    @(negedge clk);
    reset = 1'b0;
    sample_valid = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || sample_ready !== 1'b1 || dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: tx=%b busy=%b ready=%b dropped=%b expected 1 0 1 0",
               tx, busy, sample_ready, dropped);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_beats_push: busy=%b tx=%b expected 0 1", busy, tx);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    exp_bits.delete();
    add_sample(16'h12AB);
    n = exp_bits.size();
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'h12AB;
    @(negedge clk);
    sample_valid = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency: tx=%b busy=%b expected 1 1", tx, busy);
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CD; c++) begin
        @(negedge clk);
        vectors++;
        if (tx !== exp_bits[i]) begin
          miscompares++;
          $display("FAIL single_bit %0d cycle %0d: tx=%b expected %b", i, c, tx, exp_bits[i]);
        end
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_end: busy=%b tx=%b expected 0 1", busy, tx);
    end
    repeat (8) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1) begin
        miscompares++;
        $display("FAIL single_idle: tx=%b expected 1", tx);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] s [6];
    int n;
    s[0] = 16'h1111; s[1] = 16'h2233; s[2] = 16'h4455;
    s[3] = 16'h6677; s[4] = 16'h8899; s[5] = 16'hAABB;
    do_reset();
    exp_bits.delete();
    for (int k = 0; k < 5; k++) add_sample(s[k]);
    n = exp_bits.size();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          vectors++;
          if (sample_ready !== (k < 5)) begin
            miscompares++;
            $display("FAIL overflow_ready push %0d: ready=%b expected %b", k, sample_ready, k < 5);
          end
          sample_valid = 1'b1;
          sample_in = s[k];
        end
        @(negedge clk);
        sample_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          for (int c = 0; c < CD; c++) begin
            @(negedge clk);
            vectors++;
            if (tx !== exp_bits[i]) begin
              miscompares++;
              $display("FAIL overflow_bit %0d cycle %0d: tx=%b expected %b", i, c, tx, exp_bits[i]);
            end
          end
        end
      end
    join
    @(negedge clk);
    vectors++;
    if (dropped !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_end: dropped=%b busy=%b tx=%b expected 1 0 1", dropped, busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    exp_bits.delete();
    add_sample(16'h0001);
    add_sample(16'hFFFF);
    n = exp_bits.size();
    fork
      begin
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in = 16'h0001;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        sample_valid = 1'b1;
        sample_in = 16'hFFFF;
        @(negedge clk);
        sample_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
          for (int c = 0; c < CD; c++) begin
            @(negedge clk);
            vectors++;
            if (tx !== exp_bits[i]) begin
              miscompares++;
              $display("FAIL b2b_bit %0d cycle %0d: tx=%b expected %b", i, c, tx, exp_bits[i]);
            end
          end
        end
      end
    join
    @(negedge clk);
    vectors++;
    if (dropped !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end: dropped=%b busy=%b tx=%b expected 0 0 1", dropped, busy, tx);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = 16'h0F0F + 16'(k);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (28) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy_before: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || sample_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_abort: tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, sample_ready);
    end
    repeat (100) begin
      @(negedge clk);
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midframe_quiet: tx=%b busy=%b expected 1 0", tx, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
